// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline datapath and its hazard controller.
// The master modport is the datapath side, and the slave modport is the controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt_dst;
    logic             mem_reg_write;
    logic [4:0]       mem_rd_dst;
    logic             wb_reg_write;
    logic [4:0]       wb_rd_dst;
    logic             mem_pc_src;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             memwb_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_err;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_rt_dst,
               mem_reg_write, mem_rd_dst, wb_reg_write, wb_rd_dst,
               mem_pc_src, dmem_req, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
               stall_cnt, flush_cnt, mem_err
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_rt_dst,
               mem_reg_write, mem_rd_dst, wb_reg_write, wb_rd_dst,
               mem_pc_src, dmem_req, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b,
               stall_cnt, flush_cnt, mem_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline. It handles memory freezes, branch flushes,
// load-use stalls and EX forwarding. It also keeps saturating stall/flush counters and a sticky memory-timeout error.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [WCNT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q,   mem_err_d;

    logic freeze;
    logic load_use;
    logic stall_evt;
    logic flush_evt;
    logic timeout_hit;

    logic       pc_write_c, ifid_write_c, idex_write_c, exmem_write_c, memwb_write_c;
    logic       ifid_flush_c, idex_flush_c, exmem_flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign freeze      = bus.dmem_req && !bus.dmem_ready;
    assign load_use    = bus.ex_mem_read && (bus.ex_rt_dst != 5'd0) &&
                         ((bus.ex_rt_dst == bus.id_rs) || (bus.ex_rt_dst == bus.id_rt));
    assign stall_evt   = freeze || (!bus.mem_pc_src && load_use);
    assign flush_evt   = !freeze && bus.mem_pc_src;
    assign timeout_hit = (wait_cnt_q == WCNT_W'(MEM_TIMEOUT));

    // Per-cycle enables/flushes in priority order: freeze, branch, load-use, normal.
    always_comb begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_write_c  = 1'b0;
        exmem_write_c = 1'b0;
        memwb_write_c = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        fwd_a_c       = 2'b00;
        fwd_b_c       = 2'b00;
        if (rst) begin
            if (!freeze) begin
                idex_write_c  = 1'b1;
                exmem_write_c = 1'b1;
                memwb_write_c = 1'b1;
                if (bus.mem_pc_src) begin
                    pc_write_c    = 1'b1;
                    ifid_write_c  = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_flush_c  = 1'b1;
                    exmem_flush_c = 1'b1;
                end else if (load_use) begin
                    idex_flush_c  = 1'b1;
                end else begin
                    pc_write_c    = 1'b1;
                    ifid_write_c  = 1'b1;
                end
            end
            // The EX/MEM result is younger, so it takes precedence over MEM/WB.
            if (bus.mem_reg_write && (bus.mem_rd_dst != 5'd0) && (bus.mem_rd_dst == bus.ex_rs))
                fwd_a_c = 2'b10;
            else if (bus.wb_reg_write && (bus.wb_rd_dst != 5'd0) && (bus.wb_rd_dst == bus.ex_rs))
                fwd_a_c = 2'b01;
            if (bus.mem_reg_write && (bus.mem_rd_dst != 5'd0) && (bus.mem_rd_dst == bus.ex_rt))
                fwd_b_c = 2'b10;
            else if (bus.wb_reg_write && (bus.wb_rd_dst != 5'd0) && (bus.wb_rd_dst == bus.ex_rt))
                fwd_b_c = 2'b01;
        end
    end

    // Next-state logic for the wait FSM, the timeout tracker and the saturating counters.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (timeout_hit)
                    mem_err_d = 1'b1;
                if (bus.dmem_ready)
                    state_d = ST_RUN;
                else if (!timeout_hit)
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
        if (stall_evt && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_evt && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.pc_write    = pc_write_c;
    assign bus.ifid_write  = ifid_write_c;
    assign bus.idex_write  = idex_write_c;
    assign bus.exmem_write = exmem_write_c;
    assign bus.memwb_write = memwb_write_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.idex_flush  = idex_flush_c;
    assign bus.exmem_flush = exmem_flush_c;
    assign bus.fwd_a       = fwd_a_c;
    assign bus.fwd_b       = fwd_b_c;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.mem_err     = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. The stimulus side pushes reference-model expectations,
// and the monitor pops them and compares each one against the DUT on the falling edge.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
        logic       ex_mem_read;
        logic [4:0] ex_rt_dst;
        logic       mem_reg_write;
        logic [4:0] mem_rd_dst;
        logic       wb_reg_write;
        logic [4:0] wb_rd_dst;
        logic       mem_pc_src, dmem_req, dmem_ready;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [7:0] ctl;   // pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f
        logic [1:0] fa, fb;
        int         stall, flush;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    int   cyc      = 0;

    // Reference model state: pipeline frozen on memory, cycles waited so far, counters and error flag.
    bit m_waiting = 0;
    int m_waited  = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_err     = 0;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stim_t s);
        if (s.mem_reg_write && s.mem_rd_dst != 0 && s.mem_rd_dst == src) return 2'b10;
        if (s.wb_reg_write && s.wb_rd_dst != 0 && s.wb_rd_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b1, id_rs: 5'd0, id_rt: 5'd0, ex_rs: 5'd0, ex_rt: 5'd0,
              ex_mem_read: 1'b0, ex_rt_dst: 5'd0, mem_reg_write: 1'b0, mem_rd_dst: 5'd0,
              wb_reg_write: 1'b0, wb_rd_dst: 5'd0, mem_pc_src: 1'b0, dmem_req: 1'b0,
              dmem_ready: 1'b0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   frz, lu;
        @(posedge clk);
        #1;
        cyc++;
        rst               = s.rst;
        bus.id_rs         = s.id_rs;
        bus.id_rt         = s.id_rt;
        bus.ex_rs         = s.ex_rs;
        bus.ex_rt         = s.ex_rt;
        bus.ex_mem_read   = s.ex_mem_read;
        bus.ex_rt_dst     = s.ex_rt_dst;
        bus.mem_reg_write = s.mem_reg_write;
        bus.mem_rd_dst    = s.mem_rd_dst;
        bus.wb_reg_write  = s.wb_reg_write;
        bus.wb_rd_dst     = s.wb_rd_dst;
        bus.mem_pc_src    = s.mem_pc_src;
        bus.dmem_req      = s.dmem_req;
        bus.dmem_ready    = s.dmem_ready;
        e.cyc = cyc;
        if (!s.rst) begin
            m_waiting = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
            e.ctl = 8'b0; e.fa = 2'b00; e.fb = 2'b00;
            e.stall = 0; e.flush = 0; e.err = 1'b0;
        end else begin
            frz = s.dmem_req && !s.dmem_ready;
            lu  = s.ex_mem_read && s.ex_rt_dst != 0 &&
                  (s.ex_rt_dst == s.id_rs || s.ex_rt_dst == s.id_rt);
            if (frz)                e.ctl = 8'b00000_000;
            else if (s.mem_pc_src)  e.ctl = 8'b11111_111;
            else if (lu)            e.ctl = 8'b00111_010;
            else                    e.ctl = 8'b11111_000;
            e.fa = fwd_sel(s.ex_rs, s);
            e.fb = fwd_sel(s.ex_rt, s);
            e.stall = m_stall; e.flush = m_flush; e.err = m_err;
            if ((frz || (!s.mem_pc_src && lu)) && m_stall < CNT_MAX) m_stall++;
            if (!frz && s.mem_pc_src && m_flush < CNT_MAX) m_flush++;
            if (m_waiting) begin
                if (m_waited == MEM_TIMEOUT) m_err = 1;
                if (s.dmem_ready) m_waiting = 0;
                else if (m_waited < MEM_TIMEOUT) m_waited++;
            end else if (frz) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic check(input string name, input int act, input int expv, input int c);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", name, c, act, expv);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                check("ctl", int'({bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                                   bus.memwb_write, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}),
                      int'(e.ctl), e.cyc);
                check("fwd", int'({bus.fwd_a, bus.fwd_b}), int'({e.fa, e.fb}), e.cyc);
                check("stall_cnt", int'(bus.stall_cnt), e.stall, e.cyc);
                check("flush_cnt", int'(bus.flush_cnt), e.flush, e.cyc);
                check("mem_err", int'(bus.mem_err), int'(e.err), e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d act=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        s = idle(); s.rst = 1'b0;
        apply(s);
        apply(s);
        // Forwarding: EX/MEM beats MEM/WB, then MEM/WB alone once rd is r0.
        s = idle();
        s.ex_rs = 5'd5; s.mem_rd_dst = 5'd5; s.mem_reg_write = 1'b1;
        s.wb_rd_dst = 5'd5; s.wb_reg_write = 1'b1;
        apply(s);
        s.mem_rd_dst = 5'd0;
        apply(s);
        // Load-use stall.
        s = idle();
        s.ex_mem_read = 1'b1; s.ex_rt_dst = 5'd8; s.id_rt = 5'd8;
        apply(s);
        apply(idle());
        // Branch overrides load-use.
        s.mem_pc_src = 1'b1;
        apply(s);
        apply(idle());
        // Three-cycle memory wait.
        s = idle(); s.dmem_req = 1'b1;
        repeat (3) apply(s);
        s.dmem_ready = 1'b1;
        apply(s);
        apply(idle());
        // Timeout: six not-ready cycles, then ready; error must stick.
        s = idle(); s.dmem_req = 1'b1;
        repeat (6) apply(s);
        s.dmem_ready = 1'b1;
        apply(s);
        repeat (2) apply(idle());
        // Reset in the middle of a wait.
        s = idle(); s.dmem_req = 1'b1;
        repeat (3) apply(s);
        s.rst = 1'b0;
        repeat (2) apply(s);
        repeat (2) apply(idle());
        // Drive the stall counter into saturation.
        s = idle(); s.ex_mem_read = 1'b1; s.ex_rt_dst = 5'd3; s.id_rs = 5'd3;
        repeat (CNT_MAX + 6) apply(s);
        // Randomised traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            s = idle();
            s.rst           = ($urandom_range(0, 199) != 0);
            s.id_rs         = 5'($urandom_range(0, 3));
            s.id_rt         = 5'($urandom_range(0, 3));
            s.ex_rs         = 5'($urandom_range(0, 3));
            s.ex_rt         = 5'($urandom_range(0, 3));
            s.ex_mem_read   = 1'($urandom_range(0, 1));
            s.ex_rt_dst     = 5'($urandom_range(0, 3));
            s.mem_reg_write = 1'($urandom_range(0, 1));
            s.mem_rd_dst    = 5'($urandom_range(0, 3));
            s.wb_reg_write  = 1'($urandom_range(0, 1));
            s.wb_rd_dst     = 5'($urandom_range(0, 3));
            s.mem_pc_src    = ($urandom_range(0, 6) == 0);
            s.dmem_req      = ($urandom_range(0, 2) == 0);
            s.dmem_ready    = ($urandom_range(0, 3) == 0);
            apply(s);
        end
        apply(idle());
        @(negedge clk);
        @(negedge clk);
        check("drain", n_pop, n_push, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
